uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter I_CLK_FREQ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200: line rate in bit/s.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal values are 1 and 2.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_data, input, 8 bits: byte to transmit.
REQ-008 SHALL have port i_data_valid, input, 1 bit: i_data is valid.
REQ-009 SHALL have port o_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 SHALL have port o_tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL derive BAUD_DIV = I_CLK_FREQ / BAUDRATE using integer division; every bit occupies exactly BAUD_DIV clocks; BAUD_DIV < 2 is illegal and SHALL be reported at elaboration.
REQ-013 SHALL accept a byte on a rising edge where i_data_valid = 1 and o_ready = 1, capturing i_data into an internal shift register; i_data is don't-care at all other times.
REQ-014 SHALL drive o_ready = 1 only in the IDLE state, or on the last clock of the final stop bit.
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept.
- START -> DATA after BAUD_DIV clocks.
- DATA -> PARITY (PARITY != 0) or STOP after 8 bits.
- PARITY -> STOP after BAUD_DIV clocks.
- STOP -> IDLE after STOP_BITS*BAUD_DIV clocks, or -> START on back-to-back accept.
REQ-016 SHALL drive o_tx registered:
- low for the start bit, beginning the cycle after the accept edge;
- then data bits LSB first;
- then the parity bit, if enabled;
- then high for the stop bit(s).
REQ-017 SHALL compute the parity bit as even = XOR of the 8 data bits and odd = its inverse, over the captured byte.
REQ-018 SHALL give frame length BAUD_DIV*(1+8+P+STOP_BITS) clocks, where P = 1 if PARITY != 0, else 0.
REQ-019 SHALL pulse o_tx_done high for exactly one clock, coinciding with the last clock of the final stop bit.
REQ-020 SHALL, on a back-to-back accept (valid held high at end of frame), start the next start bit on the clock immediately after the last stop clock, with no idle gap.
REQ-021 SHALL hold o_tx high continuously while in IDLE.
REQ-022 SHALL ignore i_data_valid while not ready; changes to i_data mid-frame SHALL NOT affect the frame being sent.
REQ-023 SHALL reset the baud counter at each bit boundary, so that accumulated drift is zero.

Reset
REQ-024 SHALL, while i_rst_n = 0, force immediately: o_tx = 1, o_ready = 1, o_tx_done = 0, state = IDLE, all counters and the shift register = 0.
REQ-025 SHALL abandon a frame in progress when reset is asserted mid-frame, with the line returning high asynchronously; no partial frame resumes after reset is released.
REQ-026 SHALL allow a byte to be accepted on the first rising edge after reset is released.

Structure
REQ-027 SHALL take the state encodings and the PARITY codes (NONE/ODD/EVEN) from the shared package uart_pkg, which uart_rx also uses.
REQ-028 SHALL place the baud-tick counter in sub-module uart_baud_gen, which has an enable/restart input and a one-cycle tick output, and is reusable by uart_rx.

Verification
Common setup for all scenarios: I_CLK_FREQ = 10, BAUDRATE = 2 (BAUD_DIV = 5), 10 ns clock period.
REQ-029 SHALL verify: send 0x75, PARITY = 0 -> o_tx = 0, 1,0,1,0,1,1,1,0, 1, each level held 50 ns; o_tx_done pulses once at 500 ns after accept; o_ready low for 49 clocks.
REQ-030 SHALL verify: send 0x75 with PARITY = 2, then again with PARITY = 1 -> parity bit is 1 (even), then 0 (odd); frame length is 55 clocks.
REQ-031 SHALL verify: i_data_valid held high with 0xA5 then 0x3C queued -> second start bit begins on the clock after the first frame's last stop clock; no idle gap.
REQ-032 SHALL verify: i_rst_n pulsed low during data bit 4 -> o_tx = 1 within the same cycle, o_ready = 1, no o_tx_done pulse; the next byte is sent as a full, correct frame.
REQ-033 SHALL verify: STOP_BITS = 2, send 0x00 -> line is low for 45 clocks, then high for 10 clocks before o_ready re-asserts.
REQ-034 SHALL verify: i_data changed to 0xFF and i_data_valid pulsed mid-frame while sending 0x01 -> transmitted bits still encode 0x01; the second request is not accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: o_tick is high on the last clock of each DIV-clock period.
// Dropping i_en (or reaching the tick) restarts the period from zero.
module uart_baud_gen #(
  parameter int unsigned DIV = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_tick_next_c
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Look-ahead: the coming clock is the last one of the current period.
  assign o_tick_next_c = i_en && !o_tick && (cnt == CNT_W'(DIV - 2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= o_tick_next_c;
      if (!i_en || o_tick) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// back-to-back frames without idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned I_CLK_FREQ = 50_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_tx_done
);

  localparam int unsigned BAUD_DIV  = I_CLK_FREQ / BAUDRATE;
  localparam int unsigned BIT_CNT_W = 3;

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx: I_CLK_FREQ / BAUDRATE must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  uart_state_e          state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic                 par_q, par_n;
  logic                 tx_n, ready_n, done_n;
  logic                 tick, tick_next_c;
  logic                 baud_en_c, accept_c, last_stop_c;

  assign baud_en_c   = (state != ST_IDLE);
  assign accept_c    = i_data_valid && o_ready;
  assign last_stop_c = (bit_cnt == BIT_CNT_W'(STOP_BITS - 1));

  uart_baud_gen #(.DIV(BAUD_DIV)) u_baud_gen (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (baud_en_c),
    .o_tick       (tick),
    .o_tick_next_c(tick_next_c)
  );

  // Next-state and next-output logic; o_tx/o_ready/o_tx_done are registered below.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par_q;
    tx_n      = o_tx;
    done_n    = 1'b0;

    case (state)
      ST_IDLE: tx_n = 1'b1;
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          tx_n      = shreg[0];
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            if (PARITY != PARITY_NONE) begin
              state_n = ST_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n   = ST_STOP;
          tx_n      = 1'b1;
          bit_cnt_n = '0;
        end
      end
      ST_STOP: begin
        done_n = tick_next_c && last_stop_c;
        if (tick) begin
          if (last_stop_c) begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // o_ready is only high in IDLE or on the final stop clock, so accept overrides both.
    if (accept_c) begin
      state_n   = ST_START;
      shreg_n   = i_data;
      par_n     = parity_bit(i_data, PARITY);
      bit_cnt_n = '0;
      tx_n      = 1'b0;
    end

    ready_n = (state_n == ST_IDLE) || done_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_q     <= 1'b0;
      o_tx      <= 1'b1;
      o_ready   <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      par_q     <= par_n;
      o_tx      <= tx_n;
      o_ready   <= ready_n;
      o_tx_done <= done_n;
    end
  end

endmodule
